// File: rtl/activation_skew_buffer.sv
// Diagonal skew buffer between the activation memory and the systolic array west edge.
// Lane k is a shift chain of k+1 registers; a small FSM counts rows and flags when the pipes drain.
module activation_skew_buffer #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 7,
    parameter int BUS_WIDTH  = SIZE * DATA_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] act_in,
    input  logic                 act_in_valid,
    input  logic                 cal,
    output logic [BUS_WIDTH-1:0] skew_out,
    output logic [SIZE-1:0]      skew_valid,
    output logic [CNT_WIDTH-1:0] row_cnt,
    output logic                 busy,
    output logic                 drain_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   accept_s;
    logic [SIZE-1:0]        lane_pending_s;

    assign accept_s = cal & act_in_valid;

    for (genvar k = 0; k < SIZE; k++) begin : g_lane
        logic [k:0][DATA_WIDTH-1:0] data_q, data_d;
        logic [k:0]                 vld_q, vld_d;

        // Next value of the lane chain: shift in the accepted row or a zero bubble, or clear on abort.
        always_comb begin
            data_d = '0;
            vld_d  = '0;
            if (cal) begin
                vld_d[0]  = accept_s;
                data_d[0] = accept_s ? act_in[k*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
                for (int j = 1; j <= k; j++) begin
                    data_d[j] = data_q[j-1];
                    vld_d[j]  = vld_q[j-1];
                end
            end else begin
                data_d = '0;
                vld_d  = '0;
            end
        end

        // Lane chain registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_q <= '0;
                vld_q  <= '0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end

        assign skew_out[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
        assign skew_valid[k]                        = vld_q[k];

        // A lane still holds work if any register before its output stage is valid.
        if (k == 0) begin : g_first
            assign lane_pending_s[k] = 1'b0;
        end else begin : g_rest
            assign lane_pending_s[k] = |vld_q[k-1:0];
        end
    end

    // Row-tracking FSM next state, counter and completion pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (!cal) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        state_d = S_FEED;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FEED: begin
                    if (accept_s) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (accept_s) begin
                        state_d = S_FEED;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else if (lane_pending_s == {SIZE{1'b0}}) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (accept_s) begin
                        state_d = S_FEED;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state, row counter and drain_done registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign row_cnt    = cnt_q;
    assign busy       = (state_q != S_IDLE);
    assign drain_done = done_q;

endmodule

// File: tb/tb_activation_skew_buffer.sv
// Self-checking bench for activation_skew_buffer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a row-history reference model.
module tb_activation_skew_buffer;

    localparam int SIZE  = 8;
    localparam int DW    = 7;
    localparam int BUS   = SIZE * DW;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [BUS-1:0]   act_in = '0;
    logic             act_in_valid = 1'b0;
    logic             cal = 1'b0;
    logic [BUS-1:0]   skew_out;
    logic [SIZE-1:0]  skew_valid;
    logic [CNT_W-1:0] row_cnt;
    logic             busy;
    logic             drain_done;

    activation_skew_buffer #(.SIZE(SIZE), .DATA_WIDTH(DW), .BUS_WIDTH(BUS), .CNT_WIDTH(CNT_W)) dut (
        .clk(clk), .rst(rst), .act_in(act_in), .act_in_valid(act_in_valid), .cal(cal),
        .skew_out(skew_out), .skew_valid(skew_valid), .row_cnt(row_cnt),
        .busy(busy), .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    // Reference model: m_row[i] is the row applied i edges ago (zero/invalid if none or cleared).
    logic [BUS-1:0] m_row [SIZE];
    logic           m_vld [SIZE];
    int             m_cnt;
    int             m_age;   // edges since the most recent accepted row, -1 if none since clear

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < SIZE; k++) begin
            m_row[k] = '0;
            m_vld[k] = 1'b0;
        end
        m_cnt = 0;
        m_age = -1;
    endtask

    task automatic m_update(input logic c, input logic v, input logic [BUS-1:0] d);
        if (!rst || !c) begin
            m_clear();
        end else begin
            for (int k = SIZE - 1; k > 0; k--) begin
                m_row[k] = m_row[k-1];
                m_vld[k] = m_vld[k-1];
            end
            m_vld[0] = v;
            m_row[0] = v ? d : '0;
            if (v) begin
                if (m_age < 0 || m_age >= SIZE) m_cnt = 1;
                else m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_age = 0;
            end else if (m_age >= 0 && m_age <= SIZE) begin
                m_age++;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [BUS-1:0]  e_out;
            logic [SIZE-1:0] e_vld;
            for (int k = 0; k < SIZE; k++) begin
                e_vld[k] = m_vld[k];
                e_out[k*DW +: DW] = m_vld[k] ? m_row[k][k*DW +: DW] : {DW{1'b0}};
            end
            chk("cyc_skew_out", 64'(skew_out), 64'(e_out));
            chk("cyc_skew_valid", 64'(skew_valid), 64'(e_vld));
            chk("cyc_row_cnt", 64'(row_cnt), 64'(m_cnt));
            chk("cyc_busy", 64'(busy), 64'(m_age >= 0 && m_age <= SIZE));
            chk("cyc_drain_done", 64'(drain_done), 64'(m_age == SIZE));
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic step(input logic c, input logic v, input logic [BUS-1:0] d);
        cal = c;
        act_in_valid = v;
        act_in = d;
        @(posedge clk);
        m_update(c, v && c, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
    endtask

    task automatic async_reset_mid();
        #2;
        rst = 1'b0;
        m_clear();
        #1;
        chk("arst_skew_out", 64'(skew_out), 64'd0);
        chk("arst_skew_valid", 64'(skew_valid), 64'd0);
        chk("arst_row_cnt", 64'(row_cnt), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_drain", 64'(drain_done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [BUS-1:0] rand_row();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[BUS-1:0];
    endfunction

    task automatic single_row(input string tag);
        logic [BUS-1:0] d;
        logic [63:0]    e;
        for (int k = 0; k < SIZE; k++) d[k*DW +: DW] = DW'(k + 1);
        for (int t = 0; t < 11; t++) begin
            if (t == 0) step(1'b1, 1'b1, d);
            else step(1'b1, 1'b0, '0);
            e = (t < SIZE) ? (64'd1 << t) : 64'd0;
            chk({tag, "_valid"}, 64'(skew_valid), e);
            if (t < SIZE) chk({tag, "_lane"}, 64'(skew_out[t*DW +: DW]), 64'(t + 1));
            chk({tag, "_done"}, 64'(drain_done), 64'(t == 8));
            chk({tag, "_cnt"}, 64'(row_cnt), 64'd1);
        end
    endtask

    initial begin
        logic [BUS-1:0]  d;
        logic [BUS-1:0]  e_out;
        logic [SIZE-1:0] e_vld;
        int pv;

        m_clear();
        #12;
        chk("rst_skew_out", 64'(skew_out), 64'd0);
        chk("rst_skew_valid", 64'(skew_valid), 64'd0);
        chk("rst_row_cnt", 64'(row_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drain", 64'(drain_done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Single row
        single_row("s1");
        idle(4);

        // Burst of 8 rows: row r lane k = 8r+k
        for (int t = 0; t < 18; t++) begin
            for (int k = 0; k < SIZE; k++) d[k*DW +: DW] = DW'(8 * t + k);
            step(1'b1, t < 8, (t < 8) ? d : '0);
            for (int k = 0; k < SIZE; k++) begin
                e_vld[k] = (t - k >= 0) && (t - k < 8);
                e_out[k*DW +: DW] = e_vld[k] ? DW'(8 * (t - k) + k) : {DW{1'b0}};
            end
            chk("s2_out", 64'(skew_out), 64'(e_out));
            chk("s2_valid", 64'(skew_valid), 64'(e_vld));
            chk("s2_done", 64'(drain_done), 64'(t == 15));
        end
        chk("s2_cnt", 64'(row_cnt), 64'd8);
        idle(3);

        // Gap: rows at edges 0-2 and 4-5
        for (int t = 0; t < 16; t++) begin
            step(1'b1, (t <= 2) || (t == 4) || (t == 5), rand_row());
            chk("s3_done", 64'(drain_done), 64'(t == 13));
        end
        chk("s3_cnt", 64'(row_cnt), 64'd5);
        idle(3);

        // Abort: 4 rows, idle edge, cal low at edge 5 with valid held high
        for (int t = 0; t < 15; t++) begin
            if (t < 4) step(1'b1, 1'b1, rand_row());
            else if (t == 4) step(1'b1, 1'b0, '0);
            else if (t < 8) step(1'b0, 1'b1, rand_row());
            else step(1'b1, 1'b0, '0);
            if (t >= 5) begin
                chk("s4_valid", 64'(skew_valid), 64'd0);
                chk("s4_cnt", 64'(row_cnt), 64'd0);
                chk("s4_busy", 64'(busy), 64'd0);
            end
            chk("s4_done", 64'(drain_done), 64'd0);
        end

        // Async reset mid-burst, then a single row behaves as before
        for (int t = 0; t < 3; t++) step(1'b1, 1'b1, rand_row());
        async_reset_mid();
        single_row("s5");
        idle(2);

        // Back-to-back: second row accepted in the DONE cycle
        for (int t = 0; t < 20; t++) begin
            step(1'b1, (t == 0) || (t == 9), rand_row());
            chk("s6_done", 64'(drain_done), 64'((t == 8) || (t == 17)));
            if (t == 9) begin
                chk("s6_cnt", 64'(row_cnt), 64'd1);
                chk("s6_busy", 64'(busy), 64'd1);
            end
        end
        idle(2);

        // Counter wrap
        for (int t = 0; t < 260; t++) step(1'b1, 1'b1, rand_row());
        chk("wrap_cnt", 64'(row_cnt), 64'd4);
        idle(12);

        // Randomized traffic
        pv = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 40 == 0) begin
                case ($urandom_range(0, 3))
                    0: pv = 95;
                    1: pv = 50;
                    2: pv = 12;
                    default: pv = 3;
                endcase
            end
            step($urandom_range(0, 299) != 0, $urandom_range(0, 99) < pv, rand_row());
            if ($urandom_range(0, 599) == 0) async_reset_mid();
        end
        idle(12);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
